// File: rtl/event_onehot_queue.sv
// Rising-edge event capture on WIDTH request lines, issued one at a time as a
// registered one-hot word over valid/ready, in fixed-priority or round-robin order.

module event_onehot_queue_lane (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic grant,
  output logic pend,
  output logic ovf
);
  logic req_prev;
  logic edge_det;

  assign edge_det = req & ~req_prev;
  // A second edge while still pending is lost, unless this lane is being issued now.
  assign ovf      = edge_det & pend & ~grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_prev <= 1'b1;
      pend     <= 1'b0;
    end else begin
      req_prev <= req;
      pend     <= (pend & ~grant) | edge_det;
    end
  end
endmodule

module event_onehot_queue #(
  parameter int WIDTH       = 8,
  parameter int ROUND_ROBIN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic             out_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_valid,
  output logic [WIDTH-1:0] pending,
  output logic             overflow
);
  localparam int IW = $clog2(WIDTH);

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    idx;
  logic             hit;
  logic             slot_free;
  logic             load;
  logic [WIDTH-1:0] grant;
  logic [WIDTH-1:0] ovf_lane;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_lane
      event_onehot_queue_lane u_lane (
        .clk   (clk),
        .rst   (rst),
        .req   (req_in[g]),
        .grant (grant[g]),
        .pend  (pending[g]),
        .ovf   (ovf_lane[g])
      );
    end
  endgenerate

  // Scan from ptr (round-robin) or from 0 (fixed); index arithmetic wraps at WIDTH.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = (ROUND_ROBIN != 0) ? ptr + IW'(k) : IW'(k);
      if (!hit && pending[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

  assign slot_free = ~out_valid | out_ready;
  assign load      = slot_free & hit;
  assign grant     = load ? (WIDTH'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_onehot <= '0;
      out_valid  <= 1'b0;
      ptr        <= '0;
      overflow   <= 1'b0;
    end else begin
      if (slot_free) begin
        out_valid  <= load;
        out_onehot <= grant;
        if (load) ptr <= sel + 1'b1;
      end
      if (|ovf_lane)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_event_onehot_queue.sv
// Directed bench: a round-robin and a fixed-priority instance share stimulus.

module tb_event_onehot_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_in = 8'hFF;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [7:0] rr_onehot, rr_pending, fp_onehot, fp_pending;
  logic       rr_valid, rr_ovf, fp_valid, fp_ovf;

  int checks = 0;
  int errors = 0;

  event_onehot_queue #(.WIDTH(8), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst(rst), .req_in(req_in), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_onehot(rr_onehot), .out_valid(rr_valid), .pending(rr_pending), .overflow(rr_ovf)
  );

  event_onehot_queue #(.WIDTH(8), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .rst(rst), .req_in(req_in), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_onehot(fp_onehot), .out_valid(fp_valid), .pending(fp_pending), .overflow(fp_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] enc8to3(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_in = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic chk_both(input string tag, input logic [7:0] oh, input logic v, input logic [7:0] pd);
    chk({tag, "_rr_oh"}, 32'(rr_onehot), 32'(oh));
    chk({tag, "_rr_v"},  32'(rr_valid),  32'(v));
    chk({tag, "_rr_pd"}, 32'(rr_pending), 32'(pd));
    chk({tag, "_fp_oh"}, 32'(fp_onehot), 32'(oh));
    chk({tag, "_fp_v"},  32'(fp_valid),  32'(v));
    chk({tag, "_fp_pd"}, 32'(fp_pending), 32'(pd));
  endtask

  initial begin
    // Lines high through reset release produce nothing.
    rst = 1'b1; req_in = 8'hFF; out_ready = 1'b1;
    step(); step();
    chk_both("rst", 8'h00, 1'b0, 8'h00);
    chk("rst_ovf", 32'(rr_ovf | fp_ovf), 32'd0);
    rst = 1'b0;
    step(); step(); step();
    chk_both("held_ff", 8'h00, 1'b0, 8'h00);

    // Single event latency.
    req_in = 8'h00; step();
    req_in = 8'h04; step();
    chk_both("lat_pend", 8'h00, 1'b0, 8'h04);
    step();
    chk_both("lat_out", 8'h04, 1'b1, 8'h00);
    step();
    chk_both("lat_drain", 8'h00, 1'b0, 8'h00);

    // Order 0 then 7, then repeat with bit 7 held in the output.
    do_reset();
    req_in = 8'h81; step();
    chk_both("o_pend", 8'h00, 1'b0, 8'h81);
    step();
    chk_both("o_first", 8'h01, 1'b1, 8'h80);
    out_ready = 1'b1; step();
    chk_both("o_second", 8'h80, 1'b1, 8'h00);
    out_ready = 1'b0; step();
    req_in = 8'h00; step();
    req_in = 8'h81; step();
    chk_both("o_rep_pend", 8'h80, 1'b1, 8'h81);
    chk("o_rep_no_ovf", 32'(rr_ovf | fp_ovf), 32'd0);
    out_ready = 1'b1; step();
    chk_both("o_wrap1", 8'h01, 1'b1, 8'h80);
    step();
    chk_both("o_wrap2", 8'h80, 1'b1, 8'h00);
    step();
    chk_both("o_wrap_drain", 8'h00, 1'b0, 8'h00);

    // Bit 3 arrives after bit 0 issued: order 01, 08, 80.
    do_reset();
    req_in = 8'h81; step();
    step();
    chk_both("b3_first", 8'h01, 1'b1, 8'h80);
    req_in = 8'h89; step();
    chk_both("b3_pend", 8'h01, 1'b1, 8'h88);
    out_ready = 1'b1; step();
    chk_both("b3_second", 8'h08, 1'b1, 8'h80);
    step();
    chk_both("b3_third", 8'h80, 1'b1, 8'h00);
    step();

    // Round-robin and fixed priority diverge: after bit 3, pending {1,5}.
    out_ready = 1'b0; req_in = 8'h00; step();
    req_in = 8'h08; step();
    step();
    req_in = 8'h2A; step();
    chk_both("div_pend", 8'h08, 1'b1, 8'h22);
    out_ready = 1'b1; step();
    chk("div1_rr", 32'(rr_onehot), 32'h20);
    chk("div1_fp", 32'(fp_onehot), 32'h02);
    step();
    chk("div2_rr", 32'(rr_onehot), 32'h02);
    chk("div2_fp", 32'(fp_onehot), 32'h20);
    step();
    chk_both("div_drain", 8'h00, 1'b0, 8'h00);

    // Hold under backpressure.
    do_reset();
    req_in = 8'h02; step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold%0d", i), 32'(rr_onehot), 32'h02);
    end
    req_in = 8'h22; step();
    req_in = 8'h02; step();
    chk_both("hold_pend", 8'h02, 1'b1, 8'h20);
    out_ready = 1'b1; step();
    chk_both("hold_next", 8'h20, 1'b1, 8'h00);
    out_ready = 1'b0;

    // Double event on bit 6 while pending and output busy.
    req_in = 8'h42; step();
    req_in = 8'h02; step();
    req_in = 8'h42; step();
    chk_both("ovf_pend", 8'h20, 1'b1, 8'h40);
    chk("ovf_set_rr", 32'(rr_ovf), 32'd1);
    chk("ovf_set_fp", 32'(fp_ovf), 32'd1);
    out_ready = 1'b1; step();
    chk_both("ovf_issue", 8'h40, 1'b1, 8'h00);
    step();
    chk_both("ovf_once", 8'h00, 1'b0, 8'h00);
    chk("ovf_sticky", 32'(rr_ovf), 32'd1);
    ovf_clr = 1'b1; step();
    ovf_clr = 1'b0;
    chk("ovf_clr_rr", 32'(rr_ovf), 32'd0);
    chk("ovf_clr_fp", 32'(fp_ovf), 32'd0);

    // Mid-operation reset with pending 3C and output busy.
    out_ready = 1'b0; req_in = 8'h00; step();
    req_in = 8'h01; step();
    step();
    req_in = 8'h3D; step();
    chk_both("mid_pre", 8'h01, 1'b1, 8'h3C);
    rst = 1'b1; step();
    chk_both("mid_rst", 8'h00, 1'b0, 8'h00);
    rst = 1'b0; step();
    step();
    chk_both("mid_post", 8'h00, 1'b0, 8'h00);

    // Each line decodes to its own index.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_in = 8'h00; step();
      req_in = 8'(1 << i); step();
      step();
      chk($sformatf("enc%0d_v", i), 32'(rr_valid), 32'd1);
      chk($sformatf("enc%0d", i), 32'(enc8to3(rr_onehot)), 32'(i));
      chk($sformatf("enc%0d_oh", i), 32'(fp_onehot), 32'(1 << i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/event_onehot_queue.md
Name: event_onehot_queue

Overview:
- Upstream feeder for the 8:3 encoder. Captures rising edges on 8 independent request lines and holds each one as a pending event.
- Issues the pending events one at a time as a registered one-hot word over a valid/ready handshake. The encoder always receives a legal single-bit-set input.
- Ordering is fixed-priority or round-robin. Lost events are flagged.

Parameters:
- WIDTH, 8, number of request lines and one-hot output width. Must be 8 to match the 8:3 encoder; other values are out of scope.
- ROUND_ROBIN, 1, selection mode. 1 = round-robin starting after the last issued index. 0 = fixed priority, lowest index wins.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- req_in  input  WIDTH  request lines, level; each 0->1 transition is one event
- out_ready  input  1  consumer accepts out_onehot this cycle
- ovf_clr  input  1  clears the overflow flag
- out_onehot  output  WIDTH  registered one-hot event; all zero when out_valid=0
- out_valid  output  1  out_onehot holds an event
- pending  output  WIDTH  registered pending bitmap, excluding the event held in the output
- overflow  output  1  sticky; an event was lost

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset values:
  - out_onehot=0, out_valid=0, pending=0, overflow=0.
  - Internal req_prev=all ones, so lines already high at release generate no event.
  - Round-robin pointer ptr=0.
- Edge detect: edge = req_in & ~req_prev, evaluated at each rising clock edge. req_prev <= req_in every cycle.
- Output slot is free when out_valid=0, or when out_valid=1 and out_ready=1 (accept).
- Selection source at each edge is the pending register value, not this cycle's edges.
  - ROUND_ROBIN=1: search indices ptr, ptr+1, ... WIDTH-1, 0, ... ptr-1 (mod WIDTH); take the first set bit.
  - ROUND_ROBIN=0: take the lowest set index.
- Load: if the slot is free and pending≠0:
  - out_onehot <= one-hot of selected index g; out_valid <= 1.
  - Clear pending[g].
  - ptr <= (g+1) mod WIDTH.
- Drain: if the slot is free and pending=0, then out_valid <= 0 and out_onehot <= 0.
- Hold: if out_valid=1 and out_ready=0, out_onehot and out_valid hold unchanged. No reselection.
- Pending update, same edge: pending <= (pending & ~grant_clear) | edge.
  - If a new edge arrives on index g in the same cycle g is loaded, pending[g] ends at 1. The new event is queued, not merged.
- Overflow: overflow <= 1 when edge[i]=1 and pending[i]=1 and i is not being loaded this cycle.
  - The event is dropped; pending[i] stays 1.
  - An edge on an index currently held in out_onehot is not overflow; it sets pending[i].
  - ovf_clr=1 clears overflow. If an overflow condition occurs in the same cycle, set wins.
- Latency:
  - Edge sampled at clock k -> pending[i]=1 after k.
  - With the output idle, out_valid=1 with bit i after k+1.
  - Minimum 2 cycles from req_in rise to out_valid.
- Throughput: one event per cycle while out_ready=1 and pending≠0.
- out_ready with out_valid=0 has no effect.
- Reset mid-operation: all pending events, the held output and overflow are discarded. Lines held high during reset produce no event afterwards until they fall and rise again.
- req_in falling transitions and held levels generate nothing.

Test Plan:
- Reset, then req_in=8'h00 -> 8'h04 with out_ready=1 -> pending=8'h04 one cycle later; next cycle out_onehot=8'h04, out_valid=1, pending=8'h00; following cycle out_valid=0.
- req_in=8'hFF held through reset release -> no events: out_valid stays 0, pending=0.
- ROUND_ROBIN=1, out_ready=0, raise req_in 8'h00->8'h81, then issue ready pulses:
  - First issue 8'h01, then 8'h80.
  - Repeat events on bits 0 and 7 after a grant of bit 7 -> next order 8'h01, 8'h80, wrap verified.
  - With ROUND_ROBIN=0, also raise bit 3 after bit 0 is issued -> order 8'h01, 8'h08, 8'h80.
- out_ready=0 with out_onehot=8'h02 held for 5 cycles, then pulse req_in bit 5:
  - out_onehot stays 8'h02 throughout; pending=8'h20.
  - First accept -> next output 8'h20.
- Double event: pulse bit 6 (0->1->0->1) while pending[6]=1 and output busy -> overflow=1, pending=8'h40, bit 6 issued only once.
  - Assert ovf_clr -> overflow=0 next cycle.
- Mid-operation reset with pending=8'h3C and out_valid=1 -> after reset all outputs 0. Then each issued out_onehot, once decoded by the 8:3 encoder, equals the index of the line pulsed.
